// File: rtl/dmem_store_buffer_if.sv
// Processor-side and memory-side signals of the data-memory store buffer.
// The slave view belongs to the buffer; the master view belongs to the CPU/memory environment.
interface dmem_store_buffer_if;
   logic [31:0] cpu_addr;
   logic [31:0] cpu_data;
   logic        cpu_wren;
   logic        cpu_rden;
   logic [31:0] cpu_q;
   logic        cpu_stall;
   logic [31:0] mem_addr;
   logic [31:0] mem_data;
   logic        mem_wren;
   logic        mem_rden;
   logic        mem_ready;
   logic [31:0] mem_q;
   logic        empty;

   modport slave (
      input  cpu_addr, cpu_data, cpu_wren, cpu_rden, mem_ready, mem_q,
      output cpu_q, cpu_stall, mem_addr, mem_data, mem_wren, mem_rden, empty
   );

   modport master (
      output cpu_addr, cpu_data, cpu_wren, cpu_rden, mem_ready, mem_q,
      input  cpu_q, cpu_stall, mem_addr, mem_data, mem_wren, mem_rden, empty
   );
endinterface

// File: rtl/dmem_store_buffer.sv
// Posted-write buffer between the memory stage and dmem: stores drain in the background,
// loads forward from the youngest matching queued store or stall on a memory read.
module dmem_store_buffer #(
   parameter int DEPTH = 4,
   parameter int PTR_W = 2
) (
   input logic                 clock,
   input logic                 reset,
   dmem_store_buffer_if.slave  bus
);
   typedef enum logic {IDLE, LOAD_WAIT} stateT;

   stateT             state, stateNext;
   logic [31:0]       addrQ [DEPTH];
   logic [31:0]       dataQ [DEPTH];
   logic [PTR_W-1:0]  wrPtr, rdPtr;
   logic [PTR_W:0]    count;
   logic [31:0]       loadAddr;
   logic              full, hit, loadMiss, enq, drainDone;
   logic [31:0]       hitData;

   assign full      = (count == (PTR_W+1)'(DEPTH));
   assign bus.empty = (count == '0);

   // Walk oldest to youngest so the last match seen is the youngest store.
   always_comb begin
      hit     = 1'b0;
      hitData = '0;
      for (int unsigned k = 0; k < DEPTH; k++) begin
         if (count > (PTR_W+1)'(k) && addrQ[rdPtr + PTR_W'(k)] == bus.cpu_addr) begin
            hit     = 1'b1;
            hitData = dataQ[rdPtr + PTR_W'(k)];
         end
      end
   end

   always_comb begin
      stateNext     = state;
      bus.cpu_q     = '0;
      bus.cpu_stall = 1'b0;
      bus.mem_addr  = '0;
      bus.mem_data  = '0;
      bus.mem_wren  = 1'b0;
      bus.mem_rden  = 1'b0;
      loadMiss      = 1'b0;
      enq           = 1'b0;
      drainDone     = 1'b0;
      case (state)
         IDLE: begin
            if (bus.cpu_rden && !hit) begin
               loadMiss     = 1'b1;
               bus.mem_rden = 1'b1;
               bus.mem_addr = bus.cpu_addr;
               if (bus.mem_ready) begin
                  bus.cpu_q = bus.mem_q;
               end else begin
                  bus.cpu_stall = 1'b1;
                  stateNext     = LOAD_WAIT;
               end
            end else if (bus.cpu_rden) begin
               bus.cpu_q = hitData;
            end else if (bus.cpu_wren) begin
               if (full) bus.cpu_stall = 1'b1;
               else      enq           = 1'b1;
            end
         end
         LOAD_WAIT: begin
            loadMiss     = 1'b1;
            bus.mem_rden = 1'b1;
            bus.mem_addr = loadAddr;
            if (bus.mem_ready) begin
               bus.cpu_q = bus.mem_q;
               stateNext = IDLE;
            end else begin
               bus.cpu_stall = 1'b1;
            end
         end
         default: stateNext = IDLE;
      endcase
      // Drains only use the port when no load read owns it.
      if (!loadMiss && count != '0) begin
         bus.mem_wren = 1'b1;
         bus.mem_addr = addrQ[rdPtr];
         bus.mem_data = dataQ[rdPtr];
         drainDone    = bus.mem_ready;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state    <= IDLE;
         wrPtr    <= '0;
         rdPtr    <= '0;
         count    <= '0;
         loadAddr <= '0;
      end else begin
         state <= stateNext;
         if (state == IDLE && stateNext == LOAD_WAIT) loadAddr <= bus.cpu_addr;
         if (enq)       wrPtr <= wrPtr + PTR_W'(1);
         if (drainDone) rdPtr <= rdPtr + PTR_W'(1);
         count <= count + (PTR_W+1)'(enq) - (PTR_W+1)'(drainDone);
      end
   end

   // Entry payload needs no reset; validity comes from count and the pointers.
   always_ff @(posedge clock) begin
      if (enq) begin
         addrQ[wrPtr] <= bus.cpu_addr;
         dataQ[wrPtr] <= bus.cpu_data;
      end
   end
endmodule

// File: tb/tb_dmem_store_buffer.sv
// Bench for dmem_store_buffer: directed vector table, hand-written corner sequences and
// randomized traffic, all compared against a queue-based reference model.
module tb_dmem_store_buffer;
   localparam int DEPTH = 4;
   localparam bit Y = 1'b1;
   localparam bit N = 1'b0;

   logic clock;
   logic reset;
   dmem_store_buffer_if bus();

   dmem_store_buffer #(.DEPTH(DEPTH), .PTR_W(2)) dut (
      .clock(clock),
      .reset(reset),
      .bus(bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
   } entT;

   typedef struct {
      bit          wr, rd, rdy;
      logic [31:0] addr, data, q;
      bit          eStall, eWren, eRden, eEmpty;
      logic [31:0] eAddr, eQ;
   } vecT;

   entT         mq[$];
   bit          pending;
   logic [31:0] pendAddr;
   bit          lastExpStall;
   int          checks = 0;
   int          errors = 0;
   logic        sStall, sWren, sRden, sEmpty;
   logic [31:0] sAddr, sData, sQ;
   vecT         tbl[$];

   task automatic chkB(input string nm, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b", nm, act, exp);
      end
   endtask

   task automatic chkW(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // One clock cycle: drive, predict from the model, compare, clock, update the model.
   task automatic step(input bit rs, input bit wr, input bit rd, input logic [31:0] a,
                       input logic [31:0] d, input bit rdy, input logic [31:0] q);
      bit          eStall, eWren, eRden, eEmpty, hit, miss, push;
      logic [31:0] eAddr, eData, eQ;
      entT         e;
      reset = rs; bus.cpu_wren = wr; bus.cpu_rden = rd; bus.cpu_addr = a;
      bus.cpu_data = d; bus.mem_ready = rdy; bus.mem_q = q;
      #3;
      eStall = 0; eWren = 0; eRden = 0; hit = 0; miss = 0; push = 0;
      eAddr = '0; eData = '0; eQ = '0;
      eEmpty = (mq.size() == 0);
      if (pending) begin
         miss = 1; eRden = 1; eAddr = pendAddr; eStall = !rdy; eQ = rdy ? q : '0;
      end else if (rd) begin
         for (int i = mq.size() - 1; i >= 0; i--)
            if (!hit && mq[i].addr == a) begin hit = 1; eQ = mq[i].data; end
         if (!hit) begin
            miss = 1; eRden = 1; eAddr = a; eStall = !rdy; eQ = rdy ? q : '0;
         end
      end else if (wr) begin
         if (mq.size() == DEPTH) eStall = 1;
         else push = 1;
      end
      if (!miss && mq.size() > 0) begin
         eWren = 1; eAddr = mq[0].addr; eData = mq[0].data;
      end
      sStall = bus.cpu_stall; sWren = bus.mem_wren; sRden = bus.mem_rden;
      sEmpty = bus.empty; sAddr = bus.mem_addr; sData = bus.mem_data; sQ = bus.cpu_q;
      chkB("cpu_stall", sStall, eStall);
      chkB("mem_wren", sWren, eWren);
      chkB("mem_rden", sRden, eRden);
      chkB("empty", sEmpty, eEmpty);
      if (eWren || eRden) chkW("mem_addr", sAddr, eAddr);
      if (eWren) chkW("mem_data", sData, eData);
      if ((rd || pending) && !eStall) chkW("cpu_q", sQ, eQ);
      lastExpStall = eStall;
      @(posedge clock);
      #1;
      if (rs) begin
         mq.delete(); pending = 0;
      end else begin
         if (eWren && rdy) void'(mq.pop_front());
         if (push) begin e.addr = a; e.data = d; mq.push_back(e); end
         if (pending) begin
            if (rdy) pending = 0;
         end else if (miss && !rdy) begin
            pending = 1; pendAddr = a;
         end
      end
   endtask

   task automatic addVec(input bit wr, rd, rdy, input logic [31:0] addr, data, q,
                         input bit eStall, eWren, eRden, eEmpty, input logic [31:0] eAddr, eQ);
      vecT v;
      v.wr = wr; v.rd = rd; v.rdy = rdy; v.addr = addr; v.data = data; v.q = q;
      v.eStall = eStall; v.eWren = eWren; v.eRden = eRden; v.eEmpty = eEmpty;
      v.eAddr = eAddr; v.eQ = eQ;
      tbl.push_back(v);
   endtask

   task automatic drainAll();
      for (int i = 0; i < 12 && mq.size() > 0; i++) step(N, N, N, '0, '0, Y, '0);
      step(N, N, N, '0, '0, Y, '0);
      chkB("drain_to_empty", sEmpty, Y);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vecT         v;
      bit          wr, rd, rdy, holdWr;
      logic [31:0] a, d;
      int unsigned r;

      pending = 0; pendAddr = '0; holdWr = 0; a = '0; d = '0;
      reset = 1; bus.cpu_wren = 0; bus.cpu_rden = 0; bus.cpu_addr = '0;
      bus.cpu_data = '0; bus.mem_ready = 0; bus.mem_q = '0;
      @(posedge clock);
      #1;
      step(Y, N, N, '0, '0, N, '0);
      chkW("reset_cpu_q", sQ, '0);

      // wr rd rdy addr data q | stall wren rden empty eAddr eQ
      addVec(Y, N, Y, 32'h10, 32'h11, '0,        N, N, N, Y, '0, '0);
      addVec(Y, N, Y, 32'h20, 32'h22, '0,        N, Y, N, N, 32'h10, '0);
      addVec(N, N, Y, '0, '0, '0,                N, Y, N, N, 32'h20, '0);
      addVec(N, N, Y, '0, '0, '0,                N, N, N, Y, '0, '0);
      addVec(Y, N, N, 32'h40, 32'hAAAA, '0,      N, N, N, Y, '0, '0);
      addVec(Y, N, N, 32'h40, 32'hBBBB, '0,      N, Y, N, N, 32'h40, '0);
      addVec(N, Y, N, 32'h40, '0, 32'hDEAD,      N, Y, N, N, 32'h40, 32'hBBBB);
      addVec(N, N, Y, '0, '0, '0,                N, Y, N, N, 32'h40, '0);
      addVec(N, N, Y, '0, '0, '0,                N, Y, N, N, 32'h40, '0);
      addVec(Y, N, N, 32'h100, 32'h1, '0,        N, N, N, Y, '0, '0);
      addVec(Y, N, N, 32'h110, 32'h2, '0,        N, Y, N, N, 32'h100, '0);
      addVec(Y, N, N, 32'h120, 32'h3, '0,        N, Y, N, N, 32'h100, '0);
      addVec(Y, N, N, 32'h130, 32'h4, '0,        N, Y, N, N, 32'h100, '0);
      addVec(Y, N, N, 32'h140, 32'h5, '0,        Y, Y, N, N, 32'h100, '0);
      addVec(Y, N, N, 32'h140, 32'h5, '0,        Y, Y, N, N, 32'h100, '0);
      addVec(Y, N, Y, 32'h140, 32'h5, '0,        Y, Y, N, N, 32'h100, '0);
      addVec(Y, N, N, 32'h140, 32'h5, '0,        N, Y, N, N, 32'h110, '0);
      addVec(N, N, Y, '0, '0, '0,                N, Y, N, N, 32'h110, '0);
      addVec(N, N, Y, '0, '0, '0,                N, Y, N, N, 32'h120, '0);
      addVec(N, N, Y, '0, '0, '0,                N, Y, N, N, 32'h130, '0);
      addVec(N, N, Y, '0, '0, '0,                N, Y, N, N, 32'h140, '0);
      addVec(Y, N, N, 32'h50, 32'h5555, '0,      N, N, N, Y, '0, '0);
      addVec(N, Y, Y, 32'h50, '0, 32'hDEAD,      N, Y, N, N, 32'h50, 32'h5555);
      addVec(N, N, N, '0, '0, '0,                N, N, N, Y, '0, '0);

      foreach (tbl[i]) begin
         v = tbl[i];
         step(N, v.wr, v.rd, v.addr, v.data, v.rdy, v.q);
         chkB($sformatf("t%0d stall", i), sStall, v.eStall);
         chkB($sformatf("t%0d wren", i), sWren, v.eWren);
         chkB($sformatf("t%0d rden", i), sRden, v.eRden);
         chkB($sformatf("t%0d empty", i), sEmpty, v.eEmpty);
         if (v.eWren || v.eRden) chkW($sformatf("t%0d addr", i), sAddr, v.eAddr);
         if (v.rd && !v.eStall) chkW($sformatf("t%0d cpu_q", i), sQ, v.eQ);
      end

      // Load miss waiting on slow memory while a store is queued.
      step(N, Y, N, 32'h40, 32'h4040, N, '0);
      for (int i = 0; i < 3; i++) begin
         step(N, N, Y, 32'h80, '0, N, '0);
         chkB("lw rden", sRden, Y);
         chkW("lw addr", sAddr, 32'h80);
         chkB("lw stall", sStall, Y);
         chkB("lw wren", sWren, N);
      end
      step(N, N, Y, 32'h80, '0, Y, 32'h1234);
      chkW("lw cpu_q", sQ, 32'h1234);
      chkB("lw stall_drop", sStall, N);
      chkB("lw rden_last", sRden, Y);
      step(N, N, N, '0, '0, Y, '0);
      chkB("lw drain_wren", sWren, Y);
      chkW("lw drain_addr", sAddr, 32'h40);
      chkW("lw drain_data", sData, 32'h4040);
      drainAll();

      // Steady state at count 3: enqueue and drain every cycle through pointer wrap.
      for (int i = 0; i < 3; i++) step(N, Y, N, 32'h200 + 32'(i * 4), 32'(i), N, '0);
      for (int i = 0; i < 8; i++) begin
         step(N, Y, N, 32'h300 + 32'(i * 4), 32'h100 + 32'(i), Y, '0);
         chkB("ss stall", sStall, N);
         chkB("ss wren", sWren, Y);
      end
      drainAll();

      // Reset while a load is waiting with two stores queued.
      step(N, Y, N, 32'h600, 32'h6, N, '0);
      step(N, Y, N, 32'h604, 32'h7, N, '0);
      step(N, N, Y, 32'h700, '0, N, '0);
      step(Y, N, Y, 32'h700, '0, N, '0);
      chkB("rst_lw rden_before", sRden, Y);
      step(N, N, N, '0, '0, Y, '0);
      chkB("rst empty", sEmpty, Y);
      chkB("rst stall", sStall, N);
      chkB("rst rden", sRden, N);
      chkB("rst wren", sWren, N);
      for (int i = 0; i < 3; i++) begin
         step(N, N, N, '0, '0, Y, '0);
         chkB("rst no_drain", sWren, N);
      end

      // Randomized traffic over a small address set to provoke hits.
      for (int i = 0; i < 400; i++) begin
         rdy = 1'($urandom_range(0, 1));
         if (pending) begin
            wr = 0; rd = 1; a = pendAddr;
         end else if (holdWr) begin
            wr = 1; rd = 0;
         end else begin
            r = $urandom_range(0, 3);
            wr = (r == 1 || r == 3); rd = (r == 2);
            a = 32'($urandom_range(0, 7)) * 4;
            d = $urandom;
         end
         step(N, wr, rd, a, d, rdy, $urandom);
         holdWr = wr && lastExpStall;
      end
      drainAll();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
